pipo_rr_ctrl: RTL and testbench
===============================

# pipo_rr_ctrl

Round-robin controller that shares one parallel-in/parallel-out holding register between NUM_REQ producers and a single consumer. Each producer offers a word with a valid/ready handshake. The controller picks one winner per transfer, loads its word into the shared PIPO register, and presents it downstream with the winner's index. It sits between the producer blocks and the shared pipo datapath, and is the only block that drives the register's load.

## Interface

Parameters:
- DATA_WIDTH, 4, width of each word and of the shared register
- NUM_REQ, 4, number of producers, 2..16
- SRC_W, $clog2(NUM_REQ), width of the source index

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset: rst=0 resets immediately, rst=1 runs
- req_valid  input  NUM_REQ  bit i: producer i offers a word
- req_data  input  NUM_REQ*DATA_WIDTH  producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  one-hot or zero; bit i: producer i's word is taken this cycle
- out_valid  output  1  shared register holds an unconsumed word
- out_data  output  DATA_WIDTH  shared register contents
- out_src  output  SRC_W  index of the producer that wrote out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation

- State register: EMPTY (out_valid=0) and FULL (out_valid=1). This state equals out_valid.
- can_load = EMPTY, or FULL with out_ready=1.
- Arbitration is combinational:
  - Start at pointer ptr and search upward for the first set req_valid bit, wrapping modulo NUM_REQ.
  - The first set bit is the winner w.
  - req_ready = one-hot(w) when can_load=1 and any req_valid is set, else 0.
- A transfer occurs when req_valid[w] & req_ready[w]. On that edge:
  - register <= req_data[w]
  - out_src <= w
  - state <= FULL
  - ptr <= (w+1) mod NUM_REQ
- Drain: if FULL and out_ready=1 with no new transfer, state <= EMPTY. out_data and out_src keep their values.
- Simultaneous drain and fill: the new word replaces the old one and out_valid stays 1, giving one word per cycle.
- ptr moves only on a transfer. Idle cycles and stalled cycles do not move it.
- Fairness: a requester that holds req_valid is served within NUM_REQ transfers.
- Producer rules:
  - A producer must hold req_valid and req_data stable until it sees req_ready.
  - req_ready never depends on its own producer's req_data.
- out_data and out_src must not change while out_valid=1 and out_ready=0.
- out_ready while EMPTY is ignored.

## Timing

- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0, req_ready=0.
  - req_ready is 0 during reset because it is gated by rst.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N. The consumer can take it at edge N+1.
- Throughput: one word per clock when out_ready is held at 1.
- req_ready is combinational from req_valid, ptr, state and out_ready. Consumers must not make out_ready depend on req_ready.
- Reset mid-operation: the held word is dropped, outputs return to reset values at once, and ptr returns to 0. Any transfer in flight is lost.
- Reset release: the first transfer can occur on the first rising edge with rst=1.

## Structure

- Shared package or header holds the DATA_WIDTH default (4), the NUM_REQ default and the EMPTY/FULL state encodings.
- One sub-module: pipo_en, a DATA_WIDTH-wide PIPO register.
  - Inputs: clk, rst (active-low async), load enable and d. Output: q_out.
  - The controller instantiates it for out_data and drives load = transfer.
- The round-robin search is a function or generate loop inside pipo_rr_ctrl, not a separate module.

## Test plan

Defaults for all scenarios: DATA_WIDTH=4, NUM_REQ=4.

- Reset check: assert rst=0 mid-cycle with out_valid=1 and data 4'hA held. out_valid, out_data and out_src go to 0 without waiting for a clock edge. After release, the first grant goes to requester 0.
- Single producer: req_valid=4'b0100 with data 4'h5, out_ready=1. Expect req_ready=4'b0100 for one cycle, then out_valid=1, out_data=4'h5, out_src=2.
- Full contention: req_valid=4'b1111 held, data i→4'h1+i, out_ready=1. Expect out_src sequence 0,1,2,3,0,1,… with one word per cycle and no gaps.
- Backpressure: out_ready=0 while FULL with out_data=4'h3. Expect req_ready=0 and out_data/out_src stable for 5 cycles. Then raise out_ready: the next requester after the previous winner loads on the same edge that 4'h3 is consumed.
- Pointer wrap and skip: ptr=3, req_valid=4'b0011. Winner is 0, ptr becomes 1, next winner is 1.
- Drain to empty: one word in flight, no req_valid, out_ready=1. Expect out_valid 1→0 after one edge with out_data unchanged, and ptr unchanged.

Source files
------------

// File: rtl/pipo_rr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipo_rr_ctrl_pkg
//
// Shared definitions for the round-robin PIPO controller: default widths,
// the EMPTY/FULL state encoding of the shared holding register, and a small
// modulo-increment helper used to advance the arbitration pointer.
// -----------------------------------------------------------------------------
package pipo_rr_ctrl_pkg;

   localparam int DATA_WIDTH_DEF = 4;
   localparam int NUM_REQ_DEF    = 4;

   // The state bit is exported directly as out_valid, so FULL must be 1.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // (idx + 1) mod n for 0 <= idx < n, without a divider.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage : pipo_rr_ctrl_pkg

// File: rtl/pipo_rr_ctrl_pen.sv
// -----------------------------------------------------------------------------
// pipo_en
//
// WIDTH-bit parallel-in/parallel-out register with load enable.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset (clears q_out)
//   load   in   capture d on the next rising edge
//   d      in   WIDTH-bit parallel input
//   q_out  out  WIDTH-bit registered output
// -----------------------------------------------------------------------------
module pipo_en #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH-1:0] q_q;

   // NOTE: this datapath register is reset because its cleared value is
   // visible downstream; a pure data register could skip the reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= '0;
      end else if (load) begin
         // NOTE: non-blocking assignment so every flop samples pre-edge values.
         q_q <= d;
      end
   end

   assign q_out = q_q;

endmodule : pipo_en

// File: rtl/pipo_rr_ctrl.sv
// -----------------------------------------------------------------------------
// pipo_rr_ctrl
//
// Round-robin controller sharing one PIPO holding register between NUM_REQ
// producers and a single consumer. One winner per transfer is chosen by a
// rotating-priority search starting at ptr; its word is loaded into the shared
// register and presented downstream together with the winner's index.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]            producer i offers a word
//   req_data   in   [NUM_REQ*DATA_WIDTH] producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  out  [NUM_REQ]            one-hot grant, word taken this cycle
//   out_valid  out                       shared register holds an unconsumed word
//   out_data   out  [DATA_WIDTH]         shared register contents
//   out_src    out  [SRC_W]              index of the producer that wrote out_data
//   out_ready  in                        consumer accepts out_data this cycle
// -----------------------------------------------------------------------------
module pipo_rr_ctrl
   import pipo_rr_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int NUM_REQ    = NUM_REQ_DEF,
   parameter int SRC_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [SRC_W-1:0]              out_src,
   input  logic                          out_ready
);

   localparam logic [SRC_W:0]   NREQ_EXT = (SRC_W+1)'(NUM_REQ);
   localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

   state_e                  state_q;
   logic [SRC_W-1:0]        ptr_q;
   logic [SRC_W-1:0]        out_src_q;

   logic [2*NUM_REQ-1:0]    valid_dbl;
   logic [2*NUM_REQ-1:0]    valid_rot;
   logic [SRC_W-1:0]        win_off;
   logic [SRC_W:0]          win_sum;
   logic [SRC_W-1:0]        win;
   logic                    found;
   logic                    can_load;
   logic                    grant_en;
   logic                    transfer;
   logic [DATA_WIDTH-1:0]   win_data;
   logic [SRC_W-1:0]        ptr_next;

   // Rotate the doubled request vector so that bit 0 is the requester at ptr;
   // the first set bit of the low half is then the winner's offset from ptr.
   assign valid_dbl = {req_valid, req_valid};
   assign valid_rot = valid_dbl >> ptr_q;

   always_comb begin : rr_search
      // NOTE: every variable gets a default before any conditional write,
      // otherwise the tool infers a latch for the unassigned paths.
      found   = 1'b0;
      win_off = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && valid_rot[k]) begin
            found   = 1'b1;
            win_off = k[SRC_W-1:0];
         end
      end
      // ptr + offset is below 2*NUM_REQ, so one conditional subtract wraps it.
      win_sum = {1'b0, ptr_q} + {1'b0, win_off};
      if (win_sum >= NREQ_EXT) begin
         win_sum = win_sum - NREQ_EXT;
      end
      win = win_sum[SRC_W-1:0];
   end

   // Winner's word, selected with a constant-index mux.
   always_comb begin : data_mux
      win_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win == k[SRC_W-1:0]) begin
            win_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // The register can take a word when empty, or when the consumer frees it
   // on this same edge. Gating with rst keeps grants low during reset.
   assign can_load = (state_q == ST_EMPTY) || out_ready;
   assign grant_en = rst && found && can_load;
   assign transfer = grant_en;

   always_comb begin : grant_decode
      req_ready = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         req_ready[k] = grant_en && (win == k[SRC_W-1:0]);
      end
   end

   assign ptr_next = (win == LAST_IDX) ? '0 : win + SRC_W'(1);

   // Holding-register state, source index and arbitration pointer. ptr only
   // advances on a transfer, so idle or stalled cycles keep the priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_EMPTY;
         ptr_q     <= '0;
         out_src_q <= '0;
      end else if (transfer) begin
         state_q   <= ST_FULL;
         ptr_q     <= ptr_next;
         out_src_q <= win;
      end else if (state_q == ST_FULL && out_ready) begin
         state_q   <= ST_EMPTY;
      end
   end

   pipo_en #(
      .WIDTH (DATA_WIDTH)
   ) u_hold_reg (
      .clk   (clk),
      .rst   (rst),
      .load  (transfer),
      .d     (win_data),
      .q_out (out_data)
   );

   assign out_valid = (state_q == ST_FULL);
   assign out_src   = out_src_q;

   // Width sanity for the package helper; unused in logic but keeps the
   // pointer arithmetic and the helper's definition of "next" in agreement.
   localparam int PTR_AFTER_LAST = wrap_inc(NUM_REQ - 1, NUM_REQ);
   if (PTR_AFTER_LAST != 0) begin : g_bad_wrap
      $error("wrap_inc does not wrap to zero");
   end

endmodule : pipo_rr_ctrl

// File: tb/tb_pipo_rr_ctrl.sv
module tb_pipo_rr_ctrl;

   localparam int DW = 4;
   localparam int N  = 4;
   localparam int SW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic [SW-1:0]     out_src;
   logic              out_ready;

   logic [DW-1:0]     lane [N];

   int total = 0;
   int bad   = 0;

   // Behavioural reference: holding register contents plus rotating pointer.
   bit                m_full;
   logic [DW-1:0]     m_data;
   int                m_src;
   int                m_ptr;

   always #5 clk = ~clk;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = lane[i];
   end

   pipo_rr_ctrl #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   // Winner = valid requester with the smallest circular distance from ptr.
   function automatic int pick(input logic [N-1:0] v, input int p);
      int best   = -1;
      int best_d = N;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            int d = (i - p + N) % N;
            if (d < best_d) begin
               best_d = d;
               best   = i;
            end
         end
      end
      return best;
   endfunction

   function automatic logic [N-1:0] model_ready();
      logic [N-1:0] r = '0;
      int w = pick(req_valid, m_ptr);
      if (w >= 0 && (!m_full || out_ready)) r[w] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_full = 1'b0;
      m_data = '0;
      m_src  = 0;
      m_ptr  = 0;
   endtask

   // Advance one clock; the model applies the edge using pre-edge inputs.
   task automatic tick();
      int          w;
      bit          xfer;
      logic [DW-1:0] d;
      w    = pick(req_valid, m_ptr);
      xfer = (w >= 0) && (!m_full || out_ready);
      d    = (w >= 0) ? lane[w] : '0;
      @(posedge clk);
      if (xfer) begin
         m_data = d;
         m_src  = w;
         m_full = 1'b1;
         m_ptr  = (w + 1) % N;
      end else if (m_full && out_ready) begin
         m_full = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      req_valid = 4'b1111;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) lane[i] = DW'(i + 1);
      #12;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      total++; if (out_data !== 4'h0) begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
      total++; if (out_src !== 2'd0) begin bad++; $display("FAIL reset_src: got %0d want 0", out_src); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready_gated: got %b want 0000", req_ready); end
      req_valid = '0;
      @(negedge clk);
      rst = 1'b1;
      lane[1]   = 4'hA;
      req_valid = 4'b0010;
      #1;
      tick();
      req_valid = '0;
      #1;
      total++; if (out_valid !== 1'b1 || out_data !== 4'hA) begin bad++; $display("FAIL load_A: got v=%b d=%h want v=1 d=a", out_valid, out_data); end
      // Asynchronous reset in the middle of a clock phase.
      rst = 1'b0;
      model_reset();
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", out_valid); end
      total++; if (out_data !== 4'h0) begin bad++; $display("FAIL async_data: got %h want 0", out_data); end
      total++; if (out_src !== 2'd0) begin bad++; $display("FAIL async_src: got %0d want 0", out_src); end
      @(negedge clk);
      rst = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) lane[i] = DW'(i + 1);
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL post_reset_grant: got %b want 0001", req_ready); end
      tick();
      total++; if (out_src !== 2'd0 || out_data !== 4'h1) begin bad++; $display("FAIL post_reset_word: got src=%0d d=%h want src=0 d=1", out_src, out_data); end
      req_valid = '0;
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      for (int i = 0; i < N; i++) lane[i] = DW'($urandom);
      lane[2]   = 4'h5;
      req_valid = 4'b0100;
      out_ready = 1'b1;
      #1;
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", req_ready); end
      tick();
      req_valid = '0;
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_grant_drop: got %b want 0000", req_ready); end
      total++; if (out_valid !== 1'b1 || out_data !== 4'h5 || out_src !== 2'd2) begin
         bad++; $display("FAIL single_word: got v=%b d=%h s=%0d want v=1 d=5 s=2", out_valid, out_data, out_src);
      end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_contention();
      logic [N-1:0] er;
      do_reset();
      for (int i = 0; i < N; i++) lane[i] = DW'(i + 1);
      req_valid = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         er = 4'b0001 << (k % N);
         #1;
         total++; if (req_ready !== er) begin bad++; $display("FAIL contention_grant[%0d]: got %b want %b", k, req_ready, er); end
         tick();
         total++; if (out_valid !== 1'b1 || out_src !== SW'(k % N) || out_data !== DW'(k % N + 1)) begin
            bad++; $display("FAIL contention_word[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", k, out_valid, out_src, out_data, k % N, k % N + 1);
         end
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < N; i++) lane[i] = DW'(i + 1);
      req_valid = 4'b0100;
      out_ready = 1'b0;
      #1;
      tick();
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready); end
         total++; if (out_valid !== 1'b1 || out_data !== 4'h3 || out_src !== 2'd2) begin
            bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d want v=1 d=3 s=2", k, out_valid, out_data, out_src);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_release_grant: got %b want 1000", req_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== 4'h4 || out_src !== 2'd3) begin
         bad++; $display("FAIL bp_release_word: got v=%b d=%h s=%0d want v=1 d=4 s=3", out_valid, out_data, out_src);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < N; i++) lane[i] = DW'(i + 1);
      req_valid = 4'b0100;
      out_ready = 1'b1;
      #1;
      tick();
      req_valid = 4'b0011;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_grant0: got %b want 0001", req_ready); end
      tick();
      total++; if (out_src !== 2'd0) begin bad++; $display("FAIL wrap_src0: got %0d want 0", out_src); end
      #1;
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_grant1: got %b want 0010", req_ready); end
      tick();
      total++; if (out_src !== 2'd1 || out_data !== 4'h2) begin bad++; $display("FAIL wrap_src1: got s=%0d d=%h want s=1 d=2", out_src, out_data); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_drain();
      do_reset();
      lane[0]   = 4'h7;
      req_valid = 4'b0001;
      out_ready = 1'b0;
      #1;
      tick();
      req_valid = '0;
      out_ready = 1'b1;
      #1;
      tick();
      total++; if (out_valid !== 1'b0 || out_data !== 4'h7 || out_src !== 2'd0) begin
         bad++; $display("FAIL drain_word: got v=%b d=%h s=%0d want v=0 d=7 s=0", out_valid, out_data, out_src);
      end
      tick();
      tick();
      req_valid = 4'b1111;
      out_ready = 1'b0;
      #1;
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL drain_ptr_kept: got %b want 0010", req_ready); end
      req_valid = '0;
   endtask

   task automatic test_random();
      logic [N-1:0] g;
      logic [N-1:0] er;
      int           wait_cnt [N];
      do_reset();
      g = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         // Producers hold their offer until granted, then may offer again.
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || g[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               lane[i]      = DW'($urandom);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         er = model_ready();
         total++; if (req_ready !== er) begin bad++; $display("FAIL rand_grant[%0d]: got %b want %b", cyc, req_ready, er); end
         g = er;
         if (|g) begin
            for (int i = 0; i < N; i++) begin
               if (g[i]) begin
                  total++; if (wait_cnt[i] > N - 1) begin bad++; $display("FAIL rand_fair[%0d]: req %0d waited %0d transfers, limit %0d", cyc, i, wait_cnt[i], N - 1); end
                  wait_cnt[i] = 0;
               end else if (req_valid[i]) begin
                  wait_cnt[i]++;
               end else begin
                  wait_cnt[i] = 0;
               end
            end
         end
         tick();
         total++; if (out_valid !== m_full || out_data !== m_data || out_src !== SW'(m_src)) begin
            bad++; $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", cyc, out_valid, out_data, out_src, m_full, m_data, m_src);
         end
      end
      req_valid = '0;
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = '0;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) lane[i] = '0;
      model_reset();
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_wrap();
      test_drain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_pipo_rr_ctrl
